// File: rtl/hd63701_intc.sv
// hd63701_intc: turns level peripheral flags into one IRQ2 edge per service, held until the vector fetch.
// Define HD63701_INTC_RR_EN for round-robin priority; default is fixed ICF > OCF > TOF > SCI.
module hd63701_intc #(
   parameter int GAP_CYC = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] REQ,
   input  logic [3:0] ENA,
   input  logic       ACK,
   input  logic [7:0] ACKV,
   output logic       IRQ2,
   output logic [3:0] IRQ2V,
   output logic       BUSY,
   output logic [3:0] PEND
);
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;
   state_t state, state_n;
   logic [3:0] served, served_n, gcnt, gcnt_n;
   logic [1:0] sel, sel_n, win;
   logic ack_ok;
   assign PEND = REQ & ENA & ~served;
   assign IRQ2 = state == ST_WAIT;
   assign BUSY = state != ST_IDLE;
   assign IRQ2V = {1'b0, sel, 1'b0};
   assign ack_ok = state == ST_WAIT && ACK && ACKV == {4'hF, IRQ2V};
`ifdef HD63701_INTC_RR_EN
   logic [1:0] ptr;
   // ptr names the highest-priority source; search downward from it, wrapping
   always_comb begin
      win = ptr;
      for (int k = 3; k >= 0; k--)
         if (PEND[ptr - 2'(k)]) win = ptr - 2'(k);
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) ptr <= 2'd3;
      else if (ack_ok) ptr <= sel - 2'd1;
`else
   always_comb win = PEND[3] ? 2'd3 : PEND[2] ? 2'd2 : PEND[1] ? 2'd1 : 2'd0;
`endif
   always_comb begin
      state_n = state;
      sel_n = sel;
      gcnt_n = gcnt;
      served_n = served;
      case (state)
         ST_IDLE: if (|PEND) begin
            sel_n = win;
            state_n = ST_WAIT;
         end
         ST_WAIT: if (ack_ok || !(REQ[sel] && ENA[sel])) begin
            served_n[sel] = served[sel] | ack_ok;
            gcnt_n = 4'(GAP_CYC);
            state_n = ST_GAP;
         end
         ST_GAP: begin
            gcnt_n = gcnt - 4'd1;
            state_n = gcnt == 4'd1 ? ST_IDLE : ST_GAP;
         end
         default: state_n = ST_IDLE;
      endcase
      // a low flag re-arms its source, even against a same-cycle acknowledge
      served_n = served_n & REQ;
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= ST_IDLE;
         served <= '0;
         sel <= '0;
         gcnt <= '0;
      end else begin
         state <= state_n;
         served <= served_n;
         sel <= sel_n;
         gcnt <= gcnt_n;
      end
endmodule

// File: tb/tb_hd63701_intc.sv
// tb_hd63701_intc: directed stimulus pushes expected vectors; a monitor pops one per IRQ2 rising edge.
module tb_hd63701_intc;
   localparam int GAP = 3;
   logic CLK = 0, RST = 1, ACK = 0, IRQ2, BUSY;
   logic [3:0] REQ = '0, ENA = '0, IRQ2V, PEND;
   logic [7:0] ACKV = '0;
   logic [3:0] exp_q[$];
   logic [3:0] seq[5];
   logic prev_irq = 0;
   int checks = 0, errors = 0, gap, low;

   hd63701_intc #(.GAP_CYC(GAP)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .ENA(ENA), .ACK(ACK), .ACKV(ACKV),
      .IRQ2(IRQ2), .IRQ2V(IRQ2V), .BUSY(BUSY), .PEND(PEND)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (IRQ2 && !prev_irq) begin
         if (exp_q.size() == 0) chk("unexpected_irq2", IRQ2, 0);
         else chk("vector", IRQ2V, exp_q.pop_front());
      end
      prev_irq = IRQ2;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_irq(input string n);
      for (int i = 0; i < 20 && !IRQ2; i++) @(negedge CLK);
      chk(n, IRQ2, 1);
   endtask

   // acknowledge v, then count low cycles (and gap cycles) until IRQ2 returns or 12 cycles pass
   task automatic ack_gap(input logic [3:0] v, output int g, output int l);
      ACK = 1;
      ACKV = {4'hF, v};
      @(negedge CLK);
      ACK = 0;
      g = 0;
      l = 0;
      for (int i = 0; i < 12 && !IRQ2; i++) begin
         l++;
         if (BUSY) g++;
         @(negedge CLK);
      end
   endtask

   initial begin
`ifdef HD63701_INTC_RR_EN
      seq = '{4'd6, 4'd4, 4'd2, 4'd0, 4'd6};
`else
      seq = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
`endif
      tick(2);
      chk("rst_irq2", IRQ2, 0);
      chk("rst_irq2v", IRQ2V, 0);
      chk("rst_busy", BUSY, 0);
      RST = 0;
      ENA = 4'hF;
      REQ = 4'b0100;
      exp_q.push_back(4'd4);
      #1 chk("pend_ocf", PEND, 4);
      tick();
      chk("latency_irq2", IRQ2, 1);
      chk("busy_wait", BUSY, 1);
      ack_gap(4'd4, gap, low);
      chk("ocf_gap", gap, GAP);
      chk("ocf_no_refire", low, 12);
      chk("ocf_pend_served", PEND, 0);
      REQ = 4'b0000;
      tick();
      REQ = 4'b0100;
      exp_q.push_back(4'd4);
      wait_irq("ocf_rearm");
      ack_gap(4'd4, gap, low);
      chk("ocf_rearm_gap", gap, GAP);
      REQ = 4'b0000;
      tick();
      // ICF, TOF, SCI in priority order with a stray non-IRQ2 fetch in the middle
      REQ = 4'b1011;
      exp_q.push_back(4'd6);
      exp_q.push_back(4'd2);
      exp_q.push_back(4'd0);
      wait_irq("icf_req");
      ack_gap(4'd6, gap, low);
      chk("icf_gap", gap, GAP);
      chk("icf_next_rise", low, GAP + 1);
      ACK = 1;
      ACKV = 8'hFC;
      tick();
      ACK = 0;
      chk("foreign_ack_irq2", IRQ2, 1);
      chk("foreign_ack_vec", IRQ2V, 2);
      ack_gap(4'd2, gap, low);
      chk("tof_gap", gap, GAP);
      chk("tof_next_rise", low, GAP + 1);
      ack_gap(4'd0, gap, low);
      chk("sci_gap", gap, GAP);
      chk("sci_idle", low, 12);
      REQ = 4'b0000;
      tick();
      // withdrawal by disabling TOF while it waits
      REQ = 4'b0010;
      exp_q.push_back(4'd2);
      wait_irq("tof_req");
      ENA = 4'b1101;
      tick();
      chk("withdraw_irq2", IRQ2, 0);
      chk("withdraw_vec", IRQ2V, 2);
      chk("withdraw_busy", BUSY, 1);
      ENA = 4'hF;
      #1 chk("withdraw_not_served", PEND, 4'b0010);
      exp_q.push_back(4'd2);
      wait_irq("withdraw_rerequest");
      ack_gap(4'd2, gap, low);
      chk("withdraw_ack_gap", gap, GAP);
      REQ = 4'b0000;
      tick();
      // acknowledge and flag clear in the same cycle, then reset mid-service
      REQ = 4'b0100;
      exp_q.push_back(4'd4);
      wait_irq("ocf_req2");
      ACK = 1;
      ACKV = 8'hF4;
      REQ = 4'b0000;
      tick();
      ACK = 0;
      chk("ack_clear_irq2", IRQ2, 0);
      REQ = 4'b0100;
      #1 chk("ack_clear_pend", PEND, 4);
      exp_q.push_back(4'd4);
      wait_irq("ack_clear_rearm");
      #1 RST = 1;
      #1 chk("async_rst_irq2", IRQ2, 0);
      chk("async_rst_vec", IRQ2V, 0);
      chk("async_rst_busy", BUSY, 0);
      REQ = 4'b0000;
      tick();
      RST = 0;
      tick();
      // priority order with ICF re-armed during every gap
      REQ = 4'hF;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(seq[i]);
         wait_irq("order_req");
         ACK = 1;
         ACKV = {4'hF, IRQ2V};
         tick();
         ACK = 0;
         REQ[3] = 0;
         tick();
         REQ[3] = 1;
      end
      REQ = 4'b0000;
      tick(8);
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
